umem_arbiter: RTL and testbench

Arbiter and sequencer for a single shared unified memory in the 5-stage pipeline. It serves the IF-stage instruction fetch port and the MEM-stage data port, issues one access at a time to a fixed-latency memory, and returns read data with a one-cycle ack. Per-port stall signals freeze the PC/IF-ID (fetch) or the whole pipeline (data) until the ack. Data has priority, with a fairness rule so fetch is never starved.

---
 rtl/umem_pkg.sv | 24 ++
 rtl/umem_lat_cnt.sv | 32 +++
 rtl/umem_arbiter.sv | 109 ++++++++++
 tb/tb_umem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umem_pkg.sv
// rtl/umem_pkg.sv - shared types, default widths and counter sizing for the unified memory arbiter
package umem_pkg;

  localparam int UMEM_ADDR_W  = 32;
  localparam int UMEM_DATA_W  = 32;
  localparam int UMEM_MEM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } umem_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } umem_grant_t;

  // Counter must hold the value lat itself, never less than one bit wide.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/umem_lat_cnt.sv
// rtl/umem_lat_cnt.sv - saturating 1..MEM_LAT access counter with load and done
module umem_lat_cnt
  import umem_pkg::*;
#(
  parameter int MEM_LAT = UMEM_MEM_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int               CNT_W = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(MEM_LAT);

  logic [CNT_W-1:0] cnt;

  // load wins over counting so a grant in the ack cycle restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_W'(1);
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (en && (cnt < LAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LAT);

endmodule

// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - fetch/data arbiter and sequencer for a single fixed-latency unified memory
module umem_arbiter
  import umem_pkg::*;
#(
  parameter int ADDR_W  = UMEM_ADDR_W,
  parameter int DATA_W  = UMEM_DATA_W,
  parameter int MEM_LAT = UMEM_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_if,
  output logic              stall_pipe,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  umem_state_t       state;
  umem_grant_t       last_grant;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;

  logic busy;
  logic done;
  logic ack_i;
  logic ack_d;
  logic elig_i;
  logic elig_d;
  logic arb;
  logic grant_i;
  logic grant_d;

  assign busy  = (state != IDLE);
  assign ack_i = (state == BUSY_I) && done;
  assign ack_d = (state == BUSY_D) && done;

  // The port being acked sits out this arbitration, which gives the alternation.
  assign elig_i  = if_req && !ack_i;
  assign elig_d  = dm_req && !ack_d;
  assign arb     = !busy || done;
  assign grant_d = arb && elig_d && (!elig_i || (last_grant == GNT_I));
  assign grant_i = arb && elig_i && !grant_d;

  umem_lat_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_cnt (
    .clk (clk),
    .rst (rst),
    .load(grant_i || grant_d),
    .en  (busy),
    .done(done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
    end else if (grant_d) begin
      state      <= BUSY_D;
      last_grant <= GNT_D;
      lat_addr   <= dm_addr;
      lat_we     <= dm_we;
      lat_wdata  <= dm_wdata;
    end else if (grant_i) begin
      state      <= BUSY_I;
      last_grant <= GNT_I;
      lat_addr   <= if_addr;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
    end else if (arb) begin
      state <= IDLE;
    end
  end

  assign mem_en    = busy;
  assign mem_we    = busy && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign if_ack     = ack_i;
  assign dm_ack     = ack_d;
  assign if_rdata   = ack_i ? mem_rdata : '0;
  assign dm_rdata   = ack_d ? mem_rdata : '0;
  assign stall_if   = if_req && !ack_i;
  assign stall_pipe = dm_req && !ack_d;

  a_if_addr_stable : assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_I) |-> (if_addr == lat_addr));

  a_dm_addr_stable : assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_D) |-> (dm_addr == lat_addr));

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - scoreboard bench for umem_arbiter at MEM_LAT 2 and MEM_LAT 1
module tb_umem_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          chk;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dcmd_t;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;
  int   we_cnt = 0;

  logic        if_req, if_ack, dm_req, dm_we, dm_ack, stall_if, stall_pipe, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        if_req1, if_ack1, dm_req1, dm_we1, dm_ack1, stall_if1, stall_pipe1, mem_en1, mem_we1;
  logic [31:0] if_addr1, if_rdata1, dm_addr1, dm_wdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic [31:0] mem_rdata1;

  logic [31:0] mem [0:255];

  exp_t        expq[$];
  exp_t        expq1[$];
  logic [31:0] ifq[$];
  dcmd_t       dmq[$];

  umem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_if(stall_if), .stall_pipe(stall_pipe),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  umem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ack(dm_ack1),
    .stall_if(stall_if1), .stall_pipe(stall_pipe1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory for the MEM_LAT=2 instance; the MEM_LAT=1 instance reads combinationally.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      mem[0] <= 32'h2002_000A;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    if (mem_en) mem_rdata <= mem[mem_addr[9:2]];
  end
  assign mem_rdata1 = mem[mem_addr1[9:2]];

  always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic ia, input logic da,
                       input logic [31:0] ird, input logic [31:0] drd, input logic [31:0] maddr);
    check({tag, "_ack_both"}, 32'(ia & da), 32'd0);
    check({tag, "_ack_port"}, 32'(da), 32'(e.port));
    check({tag, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
    if (e.chk) check({tag, "_ack_rdata"}, da ? drd : ird, e.data);
    check({tag, "_other_rdata"}, da ? ird : drd, 32'd0);
    check({tag, "_ack_mem_addr"}, maddr, e.addr);
  endtask

  always @(negedge clk) begin
    if (if_ack || dm_ack) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL lat2_unexpected_ack if_ack=%0b dm_ack=%0b expected no ack (cycle %0d)", if_ack, dm_ack, cyc);
      end else begin
        score("lat2", expq.pop_front(), if_ack, dm_ack, if_rdata, dm_rdata, mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (if_ack1 || dm_ack1) begin
      if (expq1.size() == 0) begin
        checks++; errors++;
        $display("FAIL lat1_unexpected_ack if_ack=%0b dm_ack=%0b expected no ack (cycle %0d)", if_ack1, dm_ack1, cyc);
      end else begin
        score("lat1", expq1.pop_front(), if_ack1, dm_ack1, if_rdata1, dm_rdata1, mem_addr1);
      end
    end
  end

  initial begin : drv_if
    int n;
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (ifq.size() > 0) begin
        if_addr = ifq.pop_front(); if_req = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!if_ack && !rst && n < 64);
        if (!if_ack && !rst) begin
          checks++; errors++;
          $display("FAIL if_ack_timeout waited=%0d limit=64", n);
        end
      end else begin
        if_req = 1'b0;
      end
    end
  end

  initial begin : drv_dm
    int n;
    dcmd_t c;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dmq.size() > 0) begin
        c = dmq.pop_front();
        dm_addr = c.addr; dm_we = c.we; dm_wdata = c.wdata; dm_req = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!dm_ack && !rst && n < 64);
        if (!dm_ack && !rst) begin
          checks++; errors++;
          $display("FAIL dm_ack_timeout waited=%0d limit=64", n);
        end
      end else begin
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
  end

  task automatic start_test();
    @(negedge clk);
    t0 = cyc + 1;
  endtask

  task automatic exp_push(input bit port, input logic [31:0] data, input bit chk,
                          input logic [31:0] addr, input int c);
    exp_t e;
    e.port = port; e.data = data; e.chk = chk; e.addr = addr; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic exp1_push(input bit port, input logic [31:0] data, input int c, input logic [31:0] addr);
    exp_t e;
    e.port = port; e.data = data; e.chk = 1'b1; e.addr = addr; e.cyc = c;
    expq1.push_back(e);
  endtask

  task automatic dm_push(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    dcmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    dmq.push_back(c);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((expq.size() > 0 || expq1.size() > 0 || ifq.size() > 0 || dmq.size() > 0) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending_exp=%0d expected 0", expq.size() + expq1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  initial begin : stim
    int we_before;
    rst = 1'b1; init_mem = 1'b1;
    if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    check("rst_stalls", 32'({stall_if, stall_pipe}), 32'd0);
    check("rst_lat1_mem_en", 32'(mem_en1), 32'd0);
    @(posedge clk); #1; rst = 1'b0; init_mem = 1'b0;

    // Lone fetch of word 0.
    start_test();
    exp_push(1'b0, 32'h2002_000A, 1'b1, 32'h0, t0 + 2);
    ifq.push_back(32'h0);
    @(negedge clk); check("fetch_stall_c0", 32'(stall_if), 32'd1);
    @(negedge clk); check("fetch_stall_c1", 32'(stall_if), 32'd1);
    @(negedge clk); check("fetch_stall_c2", 32'(stall_if), 32'd0);
    wait_drain();

    // Tie from IDLE after reset: data first, then fetch with no bubble.
    do_reset();
    start_test();
    exp_push(1'b1, 32'hA500_0010, 1'b1, 32'h40, t0 + 2);
    exp_push(1'b0, 32'hA500_0001, 1'b1, 32'h4, t0 + 4);
    dm_push(1'b0, 32'h40, 32'h0);
    ifq.push_back(32'h4);
    wait_drain();

    // Both ports saturated for eight grants.
    start_test();
    exp_push(1'b1, 32'hA500_0040, 1'b1, 32'h100, t0 + 2);
    exp_push(1'b0, 32'hA500_0002, 1'b1, 32'h8,   t0 + 4);
    exp_push(1'b1, 32'hA500_0041, 1'b1, 32'h104, t0 + 6);
    exp_push(1'b0, 32'hA500_0003, 1'b1, 32'hC,   t0 + 8);
    exp_push(1'b1, 32'hA500_0042, 1'b1, 32'h108, t0 + 10);
    exp_push(1'b0, 32'hA500_0004, 1'b1, 32'h10,  t0 + 12);
    exp_push(1'b1, 32'hA500_0043, 1'b1, 32'h10C, t0 + 14);
    exp_push(1'b0, 32'hA500_0005, 1'b1, 32'h14,  t0 + 16);
    for (int k = 0; k < 4; k++) begin
      dm_push(1'b0, 32'h100 + 32'(4 * k), 32'h0);
      ifq.push_back(32'h8 + 32'(4 * k));
    end
    wait_drain();

    // Write then read back; the same port re-requesting waits one IDLE cycle.
    we_before = we_cnt;
    start_test();
    exp_push(1'b1, 32'h0, 1'b0, 32'h80, t0 + 2);
    exp_push(1'b1, 32'h1234_5678, 1'b1, 32'h80, t0 + 5);
    dm_push(1'b1, 32'h80, 32'h1234_5678);
    dm_push(1'b0, 32'h80, 32'h0);
    wait_drain();
    check("write_mem_we_cycles", 32'(we_cnt - we_before), 32'd2);

    // Reset in busy cycle 1 of a fetch aborts it without an ack.
    start_test();
    ifq.push_back(32'h10);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); check("abort_c1_if_ack", 32'(if_ack), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_if_ack", 32'(if_ack), 32'd0);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_outputs", 32'({dm_ack, mem_we, stall_if, stall_pipe}), 32'd0);
    start_test();
    exp_push(1'b1, 32'hA500_0011, 1'b1, 32'h44, t0 + 2);
    exp_push(1'b0, 32'h2002_000A, 1'b1, 32'h0, t0 + 4);
    dm_push(1'b0, 32'h44, 32'h0);
    ifq.push_back(32'h0);
    wait_drain();

    // MEM_LAT=1: both held, an ack every cycle and mem_en never drops.
    start_test();
    for (int k = 0; k < 4; k++) begin
      exp1_push(1'b1, 32'hA500_0003, t0 + 1 + 2 * k, 32'hC);
      exp1_push(1'b0, 32'hA500_0002, t0 + 2 + 2 * k, 32'h8);
    end
    @(posedge clk); #1;
    if_addr1 = 32'h8; dm_addr1 = 32'hC; if_req1 = 1'b1; dm_req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 8) dm_req1 = 1'b0;
      @(negedge clk);
      check("lat1_mem_en_busy", 32'(mem_en1), 32'd1);
    end
    @(posedge clk); #1; if_req1 = 1'b0;
    @(negedge clk); check("lat1_mem_en_idle", 32'(mem_en1), 32'd0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
